// File: rtl/tcm_mem_arb.sv
// tcm_mem_arb - tightly-coupled memory for the biRISC-V core.
//
// Purpose: a true dual-port, read-first RAM of 2^DEPTH_W 64-bit words.
//   Port 0 is a read-only 64-bit instruction fetch port. Port 1 is shared by
//   the 32-bit LSU data port and the 32-bit external (AXI-to-pmem) port. A
//   bounded-starvation arbiter gives the data port priority but forces the
//   external port through after STARVE_LIMIT consecutive denials.
//
// Optional feature: define TCM_PARITY_EN to widen the RAM to 72 bits with one
//   even-parity bit per byte; reads check the returned lanes and raise the
//   matching *_error_o alongside valid/ack. Undefined: 64-bit RAM, errors 0.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   mem_i_*  : fetch request (rd, pc) / response (accept, valid, inst, error)
//   mem_d_*  : data request (addr, data_wr, rd, wr strobes, tag, cache ops)
//              / response (accept, ack, resp_tag, data_rd, error)
//   ext_*    : external request (rd, wr strobes, addr, write_data)
//              / response (accept, ack, read_data, error)
module tcm_mem_arb #(
  parameter int DEPTH_W      = 13,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_i_rd_i,
  input  logic [31:0] mem_i_pc_i,
  output logic        mem_i_accept_o,
  output logic        mem_i_valid_o,
  output logic [63:0] mem_i_inst_o,
  output logic        mem_i_error_o,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_flush_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic [10:0] mem_d_resp_tag_o,
  output logic [31:0] mem_d_data_rd_o,
  output logic        mem_d_error_o,
  input  logic        ext_rd_i,
  input  logic [3:0]  ext_wr_i,
  input  logic [31:0] ext_addr_i,
  input  logic [31:0] ext_write_data_i,
  output logic        ext_accept_o,
  output logic        ext_ack_o,
  output logic [31:0] ext_read_data_o,
  output logic        ext_error_o
);

`ifdef TCM_PARITY_EN
  localparam int RAM_W = 72;
`else
  localparam int RAM_W = 64;
`endif
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [RAM_W-1:0]   r_mem [0:(1<<DEPTH_W)-1];
  logic [RAM_W-1:0]   r_rd0;
  logic [RAM_W-1:0]   r_rd1;
  logic [CNT_W-1:0]   r_starve_cnt;
  logic               r_i_valid;
  logic               r_d_ack;
  logic [10:0]        r_d_tag;
  logic               r_ext_ack;
  logic               r_half;

  logic               w_d_req;
  logic               w_ext_req;
  logic               w_grant_ext;
  logic               w_d_go;
  logic               w_p1_en;
  logic [31:0]        w_p1_addr;
  logic [31:0]        w_p1_wdata;
  logic [3:0]         w_p1_be;
  logic [7:0]         w_be8;
  logic [63:0]        w_wdata64;
  logic [DEPTH_W-1:0] w_idx0;
  logic [DEPTH_W-1:0] w_idx1;
  logic               w_unused_bits;

  // Arbitration: data wins unless the external port has waited STARVE_LIMIT cycles
  assign w_d_req     = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i |
                       mem_d_invalidate_i | mem_d_writeback_i;
  assign w_ext_req   = ext_rd_i | (|ext_wr_i);
  assign w_grant_ext = w_ext_req & (~w_d_req | (r_starve_cnt == LIMIT));
  assign w_d_go      = w_d_req & ~w_grant_ext;

  assign ext_accept_o   = w_grant_ext;
  assign mem_d_accept_o = ~w_grant_ext;
  assign mem_i_accept_o = 1'b1;

  // Cache maintenance ops are acked but never touch the RAM
  assign w_p1_en    = w_grant_ext | (w_d_go & (mem_d_rd_i | (|mem_d_wr_i)));
  assign w_p1_addr  = w_grant_ext ? ext_addr_i       : mem_d_addr_i;
  assign w_p1_wdata = w_grant_ext ? ext_write_data_i : mem_d_data_wr_i;
  assign w_p1_be    = w_grant_ext ? ext_wr_i         : mem_d_wr_i;
  assign w_be8      = w_p1_addr[2] ? {w_p1_be, 4'b0000} : {4'b0000, w_p1_be};
  assign w_wdata64  = {w_p1_wdata, w_p1_wdata};
  assign w_idx0     = mem_i_pc_i[DEPTH_W+2:3];
  assign w_idx1     = w_p1_addr[DEPTH_W+2:3];

  // Upper address bits alias; byte offsets are implied by strobes
  assign w_unused_bits = &{1'b0, mem_i_pc_i[31:DEPTH_W+3], mem_i_pc_i[2:0],
                           w_p1_addr[31:DEPTH_W+3], w_p1_addr[1:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_starve_cnt <= '0;
    end else if (w_grant_ext || !w_ext_req) begin
      r_starve_cnt <= '0;
    end else if (w_d_req && (r_starve_cnt != LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Response control: everything the requester sees one cycle after accept
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_i_valid <= 1'b0;
      r_d_ack   <= 1'b0;
      r_d_tag   <= '0;
      r_ext_ack <= 1'b0;
      r_half    <= 1'b0;
    end else begin
      r_i_valid <= mem_i_rd_i;
      r_d_ack   <= w_d_go;
      r_ext_ack <= w_grant_ext;
      if (w_d_go) r_d_tag <= mem_d_req_tag_i;
      if (w_p1_en) r_half <= w_p1_addr[2];
    end
  end

  // Port 0: read-only fetch; sees the pre-write value on a same-cycle collision
  always_ff @(posedge clk_i) begin
    if (mem_i_rd_i) r_rd0 <= r_mem[w_idx0];
  end

  // Port 1: read-first, byte-lane writes (parity bit rewritten per strobed lane)
  always_ff @(posedge clk_i) begin
    if (w_p1_en) begin
      for (int l = 0; l < 8; l++) begin
        if (w_be8[l]) begin
          r_mem[w_idx1][8*l +: 8] <= w_wdata64[8*l +: 8];
`ifdef TCM_PARITY_EN
          r_mem[w_idx1][64+l] <= ^w_wdata64[8*l +: 8];
`endif
        end
      end
      r_rd1 <= r_mem[w_idx1];
    end
  end

  assign mem_i_valid_o    = r_i_valid;
  assign mem_i_inst_o     = r_rd0[63:0];
  assign mem_d_ack_o      = r_d_ack;
  assign mem_d_resp_tag_o = r_d_tag;
  assign mem_d_data_rd_o  = r_half ? r_rd1[63:32] : r_rd1[31:0];
  assign ext_ack_o        = r_ext_ack;
  assign ext_read_data_o  = r_half ? r_rd1[63:32] : r_rd1[31:0];

`ifdef TCM_PARITY_EN
  logic       r_d_rd;
  logic       r_ext_rd;
  logic [7:0] w_par0;
  logic [7:0] w_par1;
  logic       w_p1_bad;

  function automatic logic [7:0] f_lane_par(input logic [63:0] d);
    logic [7:0] p;
    p = '0;
    for (int l = 0; l < 8; l++) p[l] = ^d[8*l +: 8];
    return p;
  endfunction

  // Only reads are checked; write/cache-op acks never flag an error
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_d_rd   <= 1'b0;
      r_ext_rd <= 1'b0;
    end else begin
      r_d_rd   <= w_d_go & mem_d_rd_i;
      r_ext_rd <= w_grant_ext & ext_rd_i;
    end
  end

  assign w_par0   = f_lane_par(r_rd0[63:0]);
  assign w_par1   = f_lane_par(r_rd1[63:0]);
  assign w_p1_bad = r_half ? (w_par1[7:4] != r_rd1[71:68]) : (w_par1[3:0] != r_rd1[67:64]);

  assign mem_i_error_o = r_i_valid & (w_par0 != r_rd0[71:64]);
  assign mem_d_error_o = r_d_ack & r_d_rd & w_p1_bad;
  assign ext_error_o   = r_ext_ack & r_ext_rd & w_p1_bad;
`else
  assign mem_i_error_o = 1'b0;
  assign mem_d_error_o = 1'b0;
  assign ext_error_o   = 1'b0;
`endif

endmodule

// File: tb/tb_tcm_mem_arb.sv
module tb_tcm_mem_arb;
  localparam int DW = 13;
  localparam int SL = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_i_rd_i;
  logic [31:0] mem_i_pc_i;
  logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
  logic [63:0] mem_i_inst_o;
  logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
  logic        mem_d_rd_i;
  logic [3:0]  mem_d_wr_i;
  logic [10:0] mem_d_req_tag_i;
  logic        mem_d_flush_i, mem_d_invalidate_i, mem_d_writeback_i;
  logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic [10:0] mem_d_resp_tag_o;
  logic [31:0] mem_d_data_rd_o;
  logic        ext_rd_i;
  logic [3:0]  ext_wr_i;
  logic [31:0] ext_addr_i, ext_write_data_i;
  logic        ext_accept_o, ext_ack_o, ext_error_o;
  logic [31:0] ext_read_data_o;

  // Second instance with STARVE_LIMIT=0 shares all inputs
  logic        z_i_acc, z_i_vld, z_i_err, z_d_acc, z_d_ack, z_d_err, z_e_acc, z_e_ack, z_e_err;
  logic [63:0] z_inst;
  logic [10:0] z_tag;
  logic [31:0] z_d_data, z_e_data;

  always #5 clk_i = ~clk_i;

  tcm_mem_arb #(.DEPTH_W(DW), .STARVE_LIMIT(SL)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_i_rd_i(mem_i_rd_i), .mem_i_pc_i(mem_i_pc_i),
    .mem_i_accept_o(mem_i_accept_o), .mem_i_valid_o(mem_i_valid_o),
    .mem_i_inst_o(mem_i_inst_o), .mem_i_error_o(mem_i_error_o),
    .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
    .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i), .mem_d_req_tag_i(mem_d_req_tag_i),
    .mem_d_flush_i(mem_d_flush_i), .mem_d_invalidate_i(mem_d_invalidate_i),
    .mem_d_writeback_i(mem_d_writeback_i),
    .mem_d_accept_o(mem_d_accept_o), .mem_d_ack_o(mem_d_ack_o),
    .mem_d_resp_tag_o(mem_d_resp_tag_o), .mem_d_data_rd_o(mem_d_data_rd_o),
    .mem_d_error_o(mem_d_error_o),
    .ext_rd_i(ext_rd_i), .ext_wr_i(ext_wr_i), .ext_addr_i(ext_addr_i),
    .ext_write_data_i(ext_write_data_i),
    .ext_accept_o(ext_accept_o), .ext_ack_o(ext_ack_o),
    .ext_read_data_o(ext_read_data_o), .ext_error_o(ext_error_o)
  );

  tcm_mem_arb #(.DEPTH_W(DW), .STARVE_LIMIT(0)) u_arb0 (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_i_rd_i(mem_i_rd_i), .mem_i_pc_i(mem_i_pc_i),
    .mem_i_accept_o(z_i_acc), .mem_i_valid_o(z_i_vld),
    .mem_i_inst_o(z_inst), .mem_i_error_o(z_i_err),
    .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
    .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i), .mem_d_req_tag_i(mem_d_req_tag_i),
    .mem_d_flush_i(mem_d_flush_i), .mem_d_invalidate_i(mem_d_invalidate_i),
    .mem_d_writeback_i(mem_d_writeback_i),
    .mem_d_accept_o(z_d_acc), .mem_d_ack_o(z_d_ack),
    .mem_d_resp_tag_o(z_tag), .mem_d_data_rd_o(z_d_data),
    .mem_d_error_o(z_d_err),
    .ext_rd_i(ext_rd_i), .ext_wr_i(ext_wr_i), .ext_addr_i(ext_addr_i),
    .ext_write_data_i(ext_write_data_i),
    .ext_accept_o(z_e_acc), .ext_ack_o(z_e_ack),
    .ext_read_data_o(z_e_data), .ext_error_o(z_e_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          due;
    logic [63:0] data;
    logic        chk;
    logic [10:0] tag;
    logic        err;
  } rsp_t;

  rsp_t        fq[$], dq[$], eq[$];
  logic [63:0] mm [int];
  int          bad_idx   = -1;
  int          model_cnt = 0;
  int          cyc       = 0;

  always @(negedge clk_i) begin : mon
    logic        v, g, dreq, ereq, prd, h;
    logic [3:0]  pbe;
    logic [31:0] pa, pd;
    logic [63:0] w;
    int          fi, pi, hs;
    rsp_t        r;
    if (!rst_i) begin
      fq.delete(); dq.delete(); eq.delete();
      model_cnt = 0;
    end else begin
      cyc++;
      // responses due this cycle
      while (fq.size() > 0 && fq[0].due < cyc) begin chk("i_late", 64'(fq[0].due), 64'(cyc)); void'(fq.pop_front()); end
      while (dq.size() > 0 && dq[0].due < cyc) begin chk("d_late", 64'(dq[0].due), 64'(cyc)); void'(dq.pop_front()); end
      while (eq.size() > 0 && eq[0].due < cyc) begin chk("e_late", 64'(eq[0].due), 64'(cyc)); void'(eq.pop_front()); end

      v = (fq.size() > 0) && (fq[0].due == cyc);
      chk("i_valid", 64'(mem_i_valid_o), 64'(v));
      if (v) begin
        r = fq.pop_front();
        if (r.chk) chk("i_inst", mem_i_inst_o, r.data);
        chk("i_err", 64'(mem_i_error_o), 64'(r.err));
      end else chk("i_err_idle", 64'(mem_i_error_o), 64'(0));

      v = (dq.size() > 0) && (dq[0].due == cyc);
      chk("d_ack", 64'(mem_d_ack_o), 64'(v));
      if (v) begin
        r = dq.pop_front();
        chk("d_tag", 64'(mem_d_resp_tag_o), 64'(r.tag));
        if (r.chk) chk("d_data", 64'(mem_d_data_rd_o), r.data);
        chk("d_err", 64'(mem_d_error_o), 64'(r.err));
      end else chk("d_err_idle", 64'(mem_d_error_o), 64'(0));

      v = (eq.size() > 0) && (eq[0].due == cyc);
      chk("e_ack", 64'(ext_ack_o), 64'(v));
      if (v) begin
        r = eq.pop_front();
        if (r.chk) chk("e_data", 64'(ext_read_data_o), r.data);
        chk("e_err", 64'(ext_error_o), 64'(r.err));
      end else chk("e_err_idle", 64'(ext_error_o), 64'(0));

      // arbitration for this cycle's inputs
      dreq = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i | mem_d_invalidate_i | mem_d_writeback_i;
      ereq = ext_rd_i | (|ext_wr_i);
      g    = ereq && (!dreq || model_cnt == SL);
      chk("e_accept", 64'(ext_accept_o), 64'(g));
      chk("d_accept", 64'(mem_d_accept_o), 64'(!g));
      chk("lim0_e_accept", 64'(z_e_acc), 64'(ereq));
      chk("lim0_d_accept", 64'(z_d_acc), 64'(!ereq));
      if (g || !ereq) model_cnt = 0;
      else if (model_cnt < SL) model_cnt++;

      // fetch read (sees memory before this cycle's write)
      if (mem_i_rd_i) begin
        fi = int'(mem_i_pc_i[DW+2:3]);
        r.due = cyc + 1; r.tag = '0; r.data = '0;
        r.chk = mm.exists(fi);
        if (r.chk) r.data = mm[fi];
        r.err = (fi == bad_idx);
        fq.push_back(r);
      end

      if (g) begin
        pa = ext_addr_i; pbe = ext_wr_i; pd = ext_write_data_i; prd = ext_rd_i;
      end else begin
        pa = mem_d_addr_i; pbe = dreq ? mem_d_wr_i : 4'h0; pd = mem_d_data_wr_i; prd = mem_d_rd_i;
      end
      pi = int'(pa[DW+2:3]);
      h  = pa[2];
      hs = h ? 32 : 0;
      if (g || dreq) begin
        r.due = cyc + 1; r.tag = mem_d_req_tag_i; r.data = '0;
        r.chk = prd && mm.exists(pi);
        if (r.chk) r.data = 64'(mm[pi][hs +: 32]);
        r.err = prd && (pi == bad_idx) && !h;
        if (g) eq.push_back(r);
        else   dq.push_back(r);
      end
      if (|pbe) begin
        w = '0;
        if (mm.exists(pi)) w = mm[pi];
        for (int l = 0; l < 4; l++) if (pbe[l]) w[hs + 8*l +: 8] = pd[8*l +: 8];
        mm[pi] = w;
        if (pi == bad_idx && !h && pbe[0]) bad_idx = -1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_reqs();
    mem_i_rd_i = 0; mem_d_rd_i = 0; mem_d_wr_i = 0;
    mem_d_flush_i = 0; mem_d_invalidate_i = 0; mem_d_writeback_i = 0;
    ext_rd_i = 0; ext_wr_i = 0;
  endtask

  task automatic set_d(input logic rd, input logic [3:0] wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [10:0] tag);
    mem_d_rd_i = rd; mem_d_wr_i = wr; mem_d_addr_i = a;
    mem_d_data_wr_i = d; mem_d_req_tag_i = tag;
  endtask

  initial begin
    rst_i = 1'b0;
    clear_reqs();
    mem_i_pc_i = 0; mem_d_addr_i = 0; mem_d_data_wr_i = 0; mem_d_req_tag_i = 0;
    ext_addr_i = 0; ext_write_data_i = 0;
    tick(); tick();
    chk("rst_i_valid", 64'(mem_i_valid_o), 64'(0));
    chk("rst_d_ack",   64'(mem_d_ack_o), 64'(0));
    chk("rst_d_tag",   64'(mem_d_resp_tag_o), 64'(0));
    chk("rst_e_ack",   64'(ext_ack_o), 64'(0));
    chk("rst_errs",    64'({mem_i_error_o, mem_d_error_o, ext_error_o}), 64'(0));
    rst_i = 1'b1;

    // preload words 0..7 and 32 so every later read has a known value
    for (int wd = 0; wd < 9; wd++) begin
      for (int hh = 0; hh < 2; hh++) begin
        set_d(0, 4'hF, 32'(((wd == 8) ? 32 : wd) * 8 + hh * 4),
              32'hA5000000 | 32'(((wd == 8) ? 32 : wd) << 8) | 32'(hh), 11'(wd));
        tick();
      end
    end
    clear_reqs(); tick();

    // write then immediate read-back
    set_d(0, 4'hF, 32'h104, 32'hDEADBEEF, 11'h155); tick(); clear_reqs();
    chk("wr_ack", 64'(mem_d_ack_o), 64'(1));
    chk("wr_tag", 64'(mem_d_resp_tag_o), 64'h155);
    set_d(1, 4'h0, 32'h104, 32'h0, 11'h2AA); tick(); clear_reqs();
    chk("rd_ack", 64'(mem_d_ack_o), 64'(1));
    chk("rd_tag", 64'(mem_d_resp_tag_o), 64'h2AA);
    chk("rd_data", 64'(mem_d_data_rd_o), 64'hDEADBEEF);

    // fetch of the containing 64-bit word
    mem_i_rd_i = 1; mem_i_pc_i = 32'h100; tick(); clear_reqs();
    chk("fetch_vld", 64'(mem_i_valid_o), 64'(1));
    chk("fetch_hi", 64'(mem_i_inst_o[63:32]), 64'hDEADBEEF);

    // aliased address (beyond 64 KB) and byte-strobe partial write
    set_d(1, 4'h0, 32'h0001_0104, 32'h0, 11'h011); tick(); clear_reqs();
    chk("alias_data", 64'(mem_d_data_rd_o), 64'hDEADBEEF);
    set_d(0, 4'h1, 32'h104, 32'h000000CC, 11'h012); tick(); clear_reqs();
    set_d(1, 4'h0, 32'h104, 32'h0, 11'h013); tick(); clear_reqs();
    chk("partial_data", 64'(mem_d_data_rd_o), 64'hDEADBECC);

    // cache op: acked with tag, no RAM access
    mem_d_flush_i = 1; mem_d_req_tag_i = 11'h03C; tick(); clear_reqs();
    chk("flush_ack", 64'(mem_d_ack_o), 64'(1));
    chk("flush_tag", 64'(mem_d_resp_tag_o), 64'h03C);

    // starvation: continuous data reads against a held external read
    ext_rd_i = 1; ext_addr_i = 32'h104;
    for (int i = 0; i < 5; i++) begin
      set_d(1, 4'h0, 32'(4 * i), 32'h0, 11'(i));
      #1;
      chk("starve_e_acc", 64'(ext_accept_o), 64'(i == 4));
      chk("starve_d_acc", 64'(mem_d_accept_o), 64'(i != 4));
      chk("lim0_e_acc", 64'(z_e_acc), 64'(1));
      tick();
    end
    ext_rd_i = 0; set_d(1, 4'h0, 32'h14, 32'h0, 11'h7);
    #1;
    chk("starve_e_ack", 64'(ext_ack_o), 64'(1));
    chk("starve_e_data", 64'(ext_read_data_o), 64'hDEADBECC);
    chk("lim0_d_acc", 64'(z_d_acc), 64'(1));
    tick(); clear_reqs(); tick();

    // same-cycle fetch and write to word 0x20: fetch sees old data
    mem_i_rd_i = 1; mem_i_pc_i = 32'h20;
    set_d(0, 4'hF, 32'h20, 32'h11223344, 11'h020);
    tick(); clear_reqs();
    chk("rf_old", mem_i_inst_o, 64'hA5000401_A5000400);
    mem_i_rd_i = 1; mem_i_pc_i = 32'h20; tick(); clear_reqs();
    chk("rf_new", 64'(mem_i_inst_o[31:0]), 64'h11223344);

    // external write / read path
    ext_wr_i = 4'hF; ext_addr_i = 32'h30; ext_write_data_i = 32'hCAFEF00D; tick(); clear_reqs();
    chk("ext_wr_ack", 64'(ext_ack_o), 64'(1));
    ext_rd_i = 1; ext_addr_i = 32'h30; tick(); clear_reqs();
    chk("ext_rd_data", 64'(ext_read_data_o), 64'hCAFEF00D);

    // random mixed traffic on all three ports
    for (int k = 0; k < 60; k++) begin
      int op;
      clear_reqs();
      if ($urandom_range(0, 2) != 0) begin
        mem_i_rd_i = 1;
        mem_i_pc_i = ($urandom_range(0, 4) == 0) ? 32'h104 : 32'($urandom_range(0, 63));
      end
      op = $urandom_range(0, 3);
      mem_d_addr_i = 32'($urandom_range(0, 15)) * 4;
      mem_d_req_tag_i = 11'($urandom);
      mem_d_data_wr_i = $urandom;
      case (op)
        1: mem_d_rd_i = 1;
        2: mem_d_wr_i = 4'($urandom_range(1, 15));
        3: case ($urandom_range(0, 2))
             0: mem_d_flush_i = 1;
             1: mem_d_invalidate_i = 1;
             default: mem_d_writeback_i = 1;
           endcase
        default: ;
      endcase
      op = $urandom_range(0, 2);
      ext_addr_i = 32'($urandom_range(0, 15)) * 4;
      ext_write_data_i = $urandom;
      if (op == 1) ext_rd_i = 1;
      if (op == 2) ext_wr_i = 4'($urandom_range(1, 15));
      tick();
    end
    clear_reqs(); tick(); tick();

    // reset while responses are pending; RAM must survive
    mem_i_rd_i = 1; mem_i_pc_i = 32'h100;
    set_d(1, 4'h0, 32'h104, 32'h0, 11'h055);
    tick();
    rst_i = 1'b0; clear_reqs();
    #1;
    chk("mid_rst_d_ack", 64'(mem_d_ack_o), 64'(0));
    chk("mid_rst_i_vld", 64'(mem_i_valid_o), 64'(0));
    tick(); tick();
    rst_i = 1'b1;
    set_d(1, 4'h0, 32'h104, 32'h0, 11'h056); tick(); clear_reqs();
    chk("retain_ack", 64'(mem_d_ack_o), 64'(1));
    chk("retain_data", 64'(mem_d_data_rd_o), 64'hDEADBECC);

`ifdef TCM_PARITY_EN
    set_d(0, 4'hF, 32'h8, 32'h0, 11'h008); tick(); clear_reqs();
    u_dut.r_mem[1][0] = ~u_dut.r_mem[1][0];
    mm[1][0] = ~mm[1][0];
    bad_idx = 1;
    ext_rd_i = 1; ext_addr_i = 32'h8; tick(); clear_reqs();
    chk("par_ack", 64'(ext_ack_o), 64'(1));
    chk("par_err", 64'(ext_error_o), 64'(1));
    ext_rd_i = 1; ext_addr_i = 32'hC; tick(); clear_reqs();
    chk("par_ok_ack", 64'(ext_ack_o), 64'(1));
    chk("par_ok_err", 64'(ext_error_o), 64'(0));
`endif

    tick(); tick(); tick();
    chk("sb_empty", 64'(fq.size() + dq.size() + eq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
